contadores_param: RTL and testbench
===================================

# contadores_param

Parametrised per-channel word counter for the FIFO datapath. Counts words popped from each of NUM_CH output FIFOs, latches a per-channel overflow flag, and returns a requested count through a registered req/idx readout that is only honoured while the control FSM is in its read state. It sits beside the FIFO bank and is read by the test/host side after a transfer. It replaces the fixed 4-channel, 5-bit counter.

## Interface
- NUM_CH, 4: number of counted FIFO channels (1..16)
- COUNT_W, 5: width of each counter and of `data`
- IDX_W, 2: width of `idx`; must satisfy 2^IDX_W >= NUM_CH
- READ_STATE, 4'b0100: `estado_FSM` encoding in which reads are accepted
- CLR_ON_READ, 0: 1 = an accepted read clears the channel counter it returns

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  asynchronous, active-low reset
- pop  in  NUM_CH  per-channel pop strobe; 1 = one word left FIFO this cycle
- clr  in  1  synchronous clear of all counters and overflow flags
- req  in  1  read request, sampled each cycle
- idx  in  IDX_W  channel selected by `req`
- estado_FSM  in  4  current state of the control FSM
- data  out  COUNT_W  returned count
- valid  out  1  one-cycle pulse; `data`/`idx_err` valid this cycle
- idx_err  out  1  accepted read had idx >= NUM_CH
- ovf  out  NUM_CH  sticky per-channel overflow flag

## Operation
- Counters `cnt[i]` are COUNT_W bits. Each increments by exactly 1 on every cycle that `pop[i]`=1. Each channel is independent, so all channels may increment in the same cycle.
- Overflow: a pop while `cnt[i]` = 2^COUNT_W-1 sets `ovf[i]`. `ovf[i]` is sticky until `clr` or reset. Counter behaviour at the limit is set per Configuration.
- Read acceptance: accepted in cycle N when `req`=1 and `estado_FSM`==READ_STATE. A `req` in any other state is ignored: no `valid`, and no state changes.
- Accepted read with idx < NUM_CH: `data` = value of `cnt[idx]` at cycle N, i.e. before any pop in cycle N is counted. `idx_err`=0.
- Accepted read with idx >= NUM_CH: `data`=0, `idx_err`=1, no counter affected.
- CLR_ON_READ=1: the selected counter is zeroed at the end of cycle N. A same-cycle pop on that channel gives `cnt`=1, so no word is lost. `ovf[idx]` is also cleared.
- `clr`=1: all counters and `ovf` go to 0 at the next edge, and same-cycle pops are discarded. `clr` has priority over pop and clear-on-read. A read accepted in the same cycle still returns the pre-clear value.
- Back-to-back requests: one read is accepted per cycle, with no stall. `valid` stays high for consecutive cycles.

## Timing
- Read latency: exactly 1 cycle. Request accepted at edge N gives `data`/`valid`/`idx_err` registered after edge N, visible in cycle N+1.
- `valid` is high for one cycle per accepted read. `data` and `idx_err` hold their last value when `valid`=0.
- Pop-to-count latency: 1 cycle. A `pop[i]` at edge N is visible in `cnt[i]` and readable from cycle N+1.
- Reset (rst=0, asynchronous, any time): all `cnt`=0, `ovf`=0, `data`=0, `valid`=0, `idx_err`=0. A read in flight when reset asserts is dropped. The first accepted read is possible on the first edge after `rst` deasserts.

## Configuration
- `CONTADORES_SAT_EN` defined: counters saturate. At 2^COUNT_W-1 a further pop holds the value and sets `ovf[i]`.
- Not defined (default): counters wrap from 2^COUNT_W-1 to 0 and set `ovf[i]`.
- Clear-on-read and `clr` behave identically in both builds.

## Test plan
- Reset, then 3 pops on ch0 and 7 on ch2, estado_FSM=4'b0100, req idx=2 then idx=0 back-to-back -> `valid` high 2 consecutive cycles, `data`=7 then 3, `idx_err`=0.
- req idx=1 with estado_FSM=4'b0010 -> `valid` never asserts, `data` unchanged. Same req in 4'b0100 -> `valid` with `data`=0.
- COUNT_W=5, 33 pops on ch3, read idx=3 -> wrap build: `data`=1, `ovf[3]`=1. `CONTADORES_SAT_EN` build: `data`=31, `ovf[3]`=1.
- CLR_ON_READ=1, ch1 at 4, read idx=1 with `pop[1]`=1 in the same cycle -> `data`=4. Second read gives `data`=1.
- NUM_CH=3, read idx=3 -> `valid`=1, `idx_err`=1, `data`=0, counters unchanged. Then `clr` with pops on all channels -> all reads return 0 and `ovf`=0.
- Assert rst=0 mid-sequence between two clock edges -> outputs and counters 0 immediately, with no `valid` pulse for the dropped read.

Source files
------------

// File: rtl/contadores_param.sv
// -----------------------------------------------------------------------------
// contadores_param
//
// Per-channel word counter for the FIFO datapath. One COUNT_W-bit counter per
// output FIFO counts popped words, a sticky overflow flag per channel records
// that a counter ran past its maximum, and a registered req/idx readout
// returns one channel count per cycle while the control FSM is in its read
// state.
//
// Parameters:
//   NUM_CH      number of counted channels (1..16)
//   COUNT_W     width of each counter and of data
//   IDX_W       width of idx, 2**IDX_W must be >= NUM_CH
//   READ_STATE  estado_FSM encoding in which reads are accepted
//   CLR_ON_READ 1 = an accepted read zeroes the counter (and ovf) it returns
//
// Ports:
//   clk         clock, all logic on the rising edge
//   rst         asynchronous active-low reset
//   pop         per-channel pop strobe, one word left the FIFO this cycle
//   clr         synchronous clear of all counters and overflow flags
//   req         read request, sampled every cycle
//   idx         channel selected by req
//   estado_FSM  current state of the control FSM
//   data        returned count, holds when valid is low
//   valid       one-cycle pulse per accepted read
//   idx_err     accepted read addressed a channel >= NUM_CH
//   ovf         sticky per-channel overflow flag
//
// Build option:
//   CONTADORES_SAT_EN  when defined, counters saturate at their maximum
//                      instead of wrapping to zero. ovf is set either way.
// -----------------------------------------------------------------------------
module contadores_param #(
    parameter int         NUM_CH      = 4,
    parameter int         COUNT_W     = 5,
    parameter int         IDX_W       = 2,
    parameter logic [3:0] READ_STATE  = 4'b0100,
    parameter int         CLR_ON_READ = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_CH-1:0]  pop,
    input  logic               clr,
    input  logic               req,
    input  logic [IDX_W-1:0]   idx,
    input  logic [3:0]         estado_FSM,
    output logic [COUNT_W-1:0] data,
    output logic               valid,
    output logic               idx_err,
    output logic [NUM_CH-1:0]  ovf
);

    localparam logic [COUNT_W-1:0] CNT_MAX    = '1;
    localparam logic [COUNT_W-1:0] CNT_ONE    = COUNT_W'(1);
    localparam logic [IDX_W:0]     NUM_CH_EXT = (IDX_W+1)'(NUM_CH);

`ifdef CONTADORES_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic [COUNT_W-1:0] cnt_q [NUM_CH];
    logic [COUNT_W-1:0] cnt_d [NUM_CH];
    logic [NUM_CH-1:0]  ovf_q;
    logic [NUM_CH-1:0]  ovf_d;

    logic               rd_accept;
    logic               idx_in_range;
    logic [COUNT_W-1:0] rd_value;
    logic [NUM_CH-1:0]  rd_clear_sel;

    // Read decode. The selected count is taken from the registered counters,
    // so a pop in the same cycle is never included in the returned value.
    // An out-of-range idx matches no channel, which leaves rd_value at zero
    // and selects nothing for clear-on-read.
    always_comb begin
        rd_accept    = req && (estado_FSM == READ_STATE);
        idx_in_range = ({1'b0, idx} < NUM_CH_EXT);
        rd_value     = '0;
        rd_clear_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx == IDX_W'(i)) begin
                rd_value = cnt_q[i];
                if (rd_accept && (CLR_ON_READ != 0)) begin
                    rd_clear_sel[i] = 1'b1;
                end
            end
        end
    end

    // Counter next state. Priority is clr, then clear-on-read, then pop.
    // Clear-on-read with a same-cycle pop restarts at one so the popped word
    // is not lost. At the maximum a pop raises ovf and either wraps or holds
    // depending on the build option.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = ovf_q[i];
            if (clr) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (rd_clear_sel[i]) begin
                cnt_d[i] = pop[i] ? CNT_ONE : '0;
                ovf_d[i] = 1'b0;
            end else if (pop[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_d[i] = 1'b1;
                    cnt_d[i] = SAT_EN ? CNT_MAX : '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Counter and overflow flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ovf_q <= ovf_d;
        end
    end

    // Registered readout. valid pulses once per accepted read; data and
    // idx_err only load on an accepted read so they hold between reads.
    // Reset drops any read that was accepted but not yet registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data    <= '0;
            valid   <= 1'b0;
            idx_err <= 1'b0;
        end else begin
            valid <= rd_accept;
            if (rd_accept) begin
                data    <= rd_value;
                idx_err <= !idx_in_range;
            end
        end
    end

    assign ovf = ovf_q;

endmodule

// File: tb/tb_contadores_param.sv
// -----------------------------------------------------------------------------
// tb_contadores_param
//
// Drives two instances of contadores_param from one shared stimulus:
//   u0: NUM_CH=4, CLR_ON_READ=0
//   u1: NUM_CH=3, CLR_ON_READ=1 (sees pop[2:0])
// A behavioural model of both channel banks predicts every output every
// cycle; directed steps additionally check fixed values from the test plan.
// Honours CONTADORES_SAT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_contadores_param;

    localparam int         MAXV = 31;
    localparam logic [3:0] RD   = 4'b0100;

`ifdef CONTADORES_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] pop;
    logic       clr;
    logic       req;
    logic [1:0] idx;
    logic [3:0] estado_FSM;

    logic [4:0] data0, data1;
    logic       valid0, valid1;
    logic       err0, err1;
    logic [3:0] ovf0;
    logic [2:0] ovf1;

    int errors = 0;
    int checks = 0;

    // Model state, index 0 = u0, index 1 = u1.
    int mcnt   [2][4];
    bit movf   [2][4];
    int mdata  [2];
    bit mvalid [2];
    bit merr   [2];
    int nch    [2] = '{4, 3};
    bit cor    [2] = '{1'b0, 1'b1};

    always #5 clk = ~clk;

    contadores_param #(
        .NUM_CH(4), .COUNT_W(5), .IDX_W(2), .READ_STATE(4'b0100), .CLR_ON_READ(0)
    ) u0 (
        .clk(clk), .rst(rst), .pop(pop), .clr(clr), .req(req), .idx(idx),
        .estado_FSM(estado_FSM), .data(data0), .valid(valid0), .idx_err(err0),
        .ovf(ovf0)
    );

    contadores_param #(
        .NUM_CH(3), .COUNT_W(5), .IDX_W(2), .READ_STATE(4'b0100), .CLR_ON_READ(1)
    ) u1 (
        .clk(clk), .rst(rst), .pop(pop[2:0]), .clr(clr), .req(req), .idx(idx),
        .estado_FSM(estado_FSM), .data(data1), .valid(valid1), .idx_err(err1),
        .ovf(ovf1)
    );

    // Reset puts every model count, flag and output to zero.
    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 4; c++) begin
                mcnt[k][c] = 0;
                movf[k][c] = 1'b0;
            end
            mdata[k]  = 0;
            mvalid[k] = 1'b0;
            merr[k]   = 1'b0;
        end
    endtask

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic modelStep();
        bit acc;
        acc = req && (estado_FSM == RD);
        for (int k = 0; k < 2; k++) begin
            mvalid[k] = acc;
            if (acc) begin
                if (int'(idx) < nch[k]) begin
                    mdata[k] = mcnt[k][idx];
                    merr[k]  = 1'b0;
                end else begin
                    mdata[k] = 0;
                    merr[k]  = 1'b1;
                end
            end
            for (int c = 0; c < nch[k]; c++) begin
                if (clr) begin
                    mcnt[k][c] = 0;
                    movf[k][c] = 1'b0;
                end else if (acc && cor[k] && int'(idx) == c) begin
                    mcnt[k][c] = pop[c] ? 1 : 0;
                    movf[k][c] = 1'b0;
                end else if (pop[c]) begin
                    if (mcnt[k][c] == MAXV) begin
                        movf[k][c] = 1'b1;
                        mcnt[k][c] = SAT ? MAXV : 0;
                    end else begin
                        mcnt[k][c] = mcnt[k][c] + 1;
                    end
                end
            end
        end
    endtask

    // One comparison: counted, and reported on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Compares every output of both instances against the model.
    task automatic checkAll();
        logic [3:0] e0;
        logic [2:0] e1;
        for (int c = 0; c < 4; c++) e0[c] = movf[0][c];
        for (int c = 0; c < 3; c++) e1[c] = movf[1][c];
        checkOutput("u0.valid", 32'(valid0), 32'(mvalid[0]));
        checkOutput("u0.data",  32'(data0),  32'(mdata[0]));
        checkOutput("u0.idx_err", 32'(err0), 32'(merr[0]));
        checkOutput("u0.ovf",   32'(ovf0),   32'(e0));
        checkOutput("u1.valid", 32'(valid1), 32'(mvalid[1]));
        checkOutput("u1.data",  32'(data1),  32'(mdata[1]));
        checkOutput("u1.idx_err", 32'(err1), 32'(merr[1]));
        checkOutput("u1.ovf",   32'(ovf1),   32'(e1));
    endtask

    // Drives one cycle of inputs, steps the model, and checks after the edge.
    task automatic applyStimulus(input logic [3:0] p, input logic c, input logic r,
                                 input logic [1:0] i, input logic [3:0] e);
        pop        = p;
        clr        = c;
        req        = r;
        idx        = i;
        estado_FSM = e;
        modelStep();
        @(posedge clk);
        #1;
        checkAll();
    endtask

    initial begin
        rst        = 1'b0;
        pop        = '0;
        clr        = 1'b0;
        req        = 1'b0;
        idx        = '0;
        estado_FSM = '0;
        modelReset();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkAll();
        checkOutput("reset.data0", 32'(data0), 32'd0);
        rst = 1'b1;

        // 3 pops on ch0, 7 on ch2, then back-to-back reads idx2, idx0.
        $display("[TB] basic counting and back-to-back reads");
        for (int n = 0; n < 7; n++) begin
            applyStimulus({1'b0, 1'b1, 1'b0, (n < 3) ? 1'b1 : 1'b0}, 1'b0, 1'b0, 2'd0, 4'b0000);
        end
        applyStimulus(4'b0000, 1'b0, 1'b1, 2'd2, RD);
        checkOutput("b2b.first.valid", 32'(valid0), 32'd1);
        checkOutput("b2b.first.data",  32'(data0),  32'd7);
        applyStimulus(4'b0000, 1'b0, 1'b1, 2'd0, RD);
        checkOutput("b2b.second.valid", 32'(valid0), 32'd1);
        checkOutput("b2b.second.data",  32'(data0),  32'd3);
        checkOutput("b2b.second.err",   32'(err0),   32'd0);
        checkOutput("b2b.u1.data",      32'(data1),  32'd3);

        // Request outside the read state is ignored.
        $display("[TB] request outside read state");
        applyStimulus(4'b0000, 1'b0, 1'b1, 2'd1, 4'b0010);
        checkOutput("wrongstate.valid", 32'(valid0), 32'd0);
        checkOutput("wrongstate.data",  32'(data0),  32'd3);
        applyStimulus(4'b0000, 1'b0, 1'b1, 2'd1, RD);
        checkOutput("rightstate.valid", 32'(valid0), 32'd1);
        checkOutput("rightstate.data",  32'(data0),  32'd0);

        // 33 pops on ch3: wrap gives 1, saturate gives 31, ovf set either way.
        $display("[TB] overflow on ch3");
        for (int n = 0; n < 33; n++) begin
            applyStimulus(4'b1000, 1'b0, 1'b0, 2'd0, 4'b0000);
        end
        applyStimulus(4'b0000, 1'b0, 1'b1, 2'd3, RD);
        checkOutput("ovf.data",   32'(data0),   SAT ? 32'd31 : 32'd1);
        checkOutput("ovf.flag",   32'(ovf0[3]), 32'd1);
        checkOutput("idx3.err",   32'(err1),    32'd1);
        checkOutput("idx3.data",  32'(data1),   32'd0);
        checkOutput("idx3.valid", 32'(valid1),  32'd1);

        // Clear-on-read with a same-cycle pop keeps the popped word.
        $display("[TB] clear on read");
        for (int n = 0; n < 4; n++) begin
            applyStimulus(4'b0010, 1'b0, 1'b0, 2'd0, 4'b0000);
        end
        applyStimulus(4'b0010, 1'b0, 1'b1, 2'd1, RD);
        checkOutput("cor.first.u1",  32'(data1), 32'd4);
        checkOutput("cor.first.u0",  32'(data0), 32'd4);
        applyStimulus(4'b0000, 1'b0, 1'b1, 2'd1, RD);
        checkOutput("cor.second.u1", 32'(data1), 32'd1);
        checkOutput("cor.second.u0", 32'(data0), 32'd5);

        // clr with pops on all channels and a same-cycle read.
        $display("[TB] synchronous clear");
        applyStimulus(4'b1111, 1'b1, 1'b1, 2'd3, RD);
        checkOutput("clr.preclear.data", 32'(data0), SAT ? 32'd31 : 32'd1);
        checkOutput("clr.ovf0", 32'(ovf0), 32'd0);
        checkOutput("clr.ovf1", 32'(ovf1), 32'd0);
        for (int n = 0; n < 4; n++) begin
            applyStimulus(4'b0000, 1'b0, 1'b1, 2'(n), RD);
            checkOutput("clr.read", 32'(data0), 32'd0);
        end

        // Randomised traffic.
        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus(4'($urandom),
                          ($urandom_range(0, 29) == 0),
                          1'($urandom),
                          2'($urandom),
                          ($urandom_range(0, 3) == 0) ? 4'($urandom) : RD);
        end

        // Asynchronous reset between edges drops the in-flight read.
        $display("[TB] asynchronous reset mid-cycle");
        pop        = 4'b1111;
        clr        = 1'b0;
        req        = 1'b1;
        idx        = 2'd0;
        estado_FSM = RD;
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        checkAll();
        checkOutput("areset.valid", 32'(valid0), 32'd0);
        checkOutput("areset.ovf",   32'(ovf0),   32'd0);
        @(posedge clk);
        #1;
        checkAll();
        checkOutput("areset.hold.valid", 32'(valid0), 32'd0);
        rst = 1'b1;
        pop = '0;
        req = 1'b0;
        for (int n = 0; n < 4; n++) begin
            applyStimulus(4'b0000, 1'b0, 1'b1, 2'(n), RD);
            checkOutput("postreset.data", 32'(data0), 32'd0);
        end
        applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0, RD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
